branch_resolver: RTL and testbench

//  Consumer end of the branch predictor's prediction bit. Queues each fetched branch's

---
 rtl/branch_resolver_pkg.sv | 9 +
 rtl/branch_resolver_if.sv | 62 ++++++
 rtl/branch_resolver_pred_fifo.sv | 57 +++++
 rtl/branch_resolver.sv | 81 ++++++++
 tb/tb_branch_resolver.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared defaults for the branch resolver slice.
// Optional feature macro: BR_PERF_CNT_EN (perf counters).
package br_pkg;

  localparam int BR_ADDR_W = 32;
  localparam int BR_DEPTH  = 4;
  localparam int RESET_PC  = 0;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/EXE/predictor-update bundle of the branch resolver.
// BR_PERF_CNT_EN adds the perf counter outputs.
interface branch_resolver_if
  import br_pkg::*;
#(
  parameter int ADDR_W = BR_ADDR_W
);

  logic              fetch_valid;
  logic              fetch_pred;
  logic              fetch_ready;
  logic              exe_valid;
  logic              exe_taken;
  logic [ADDR_W-1:0] exe_target;
  logic [ADDR_W-1:0] exe_pc_plus4;
  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;
  logic              upd_valid;
  logic              upd_taken;
  logic              underflow;
`ifdef BR_PERF_CNT_EN
  logic [31:0]       perf_branches;
  logic [31:0]       perf_mispredicts;
`endif

`ifdef BR_PERF_CNT_EN
  modport master (
    output fetch_valid, fetch_pred,
    output exe_valid, exe_taken,
    output exe_target, exe_pc_plus4,
    input  fetch_ready, flush, redirect_pc,
    input  upd_valid, upd_taken, underflow,
    input  perf_branches, perf_mispredicts
  );

  modport slave (
    input  fetch_valid, fetch_pred,
    input  exe_valid, exe_taken,
    input  exe_target, exe_pc_plus4,
    output fetch_ready, flush, redirect_pc,
    output upd_valid, upd_taken, underflow,
    output perf_branches, perf_mispredicts
  );
`else
  modport master (
    output fetch_valid, fetch_pred,
    output exe_valid, exe_taken,
    output exe_target, exe_pc_plus4,
    input  fetch_ready, flush, redirect_pc,
    input  upd_valid, upd_taken, underflow
  );

  modport slave (
    input  fetch_valid, fetch_pred,
    input  exe_valid, exe_taken,
    input  exe_target, exe_pc_plus4,
    output fetch_ready, flush, redirect_pc,
    output upd_valid, upd_taken, underflow
  );
`endif

endinterface

// File: rtl/branch_resolver_pred_fifo.sv
// In-order queue of 1-bit branch predictions.
// Clear drops every entry (wrong-path flush).
module pred_fifo #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  input  logic clear,
  output logic full,
  output logic empty,
  output logic head_data
);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full      = count == (PTR_W+1)'(DEPTH);
  assign empty     = count == '0;
  assign head_data = mem[head];
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;

  // Pointer, occupancy and storage update; clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= din;
        tail      <= tail + 1'b1;
      end
      if (do_pop) begin
        head <= head + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves queued predictions against EXE outcomes in order.
// BR_PERF_CNT_EN adds saturating resolve/mispredict counters.
module branch_resolver
  import br_pkg::*;
#(
  parameter int DEPTH  = BR_DEPTH,
  parameter int ADDR_W = BR_ADDR_W
) (
  input logic clk,
  input logic rst,
  branch_resolver_if.slave bus
);

  logic full;
  logic empty;
  logic head_pred;
  logic resolve;
  logic mispred;
  logic push_ok;

  assign resolve = bus.exe_valid & ~empty;
  assign mispred = resolve & (head_pred != bus.exe_taken);
  assign push_ok = bus.fetch_valid & ~full & ~mispred;
  assign bus.fetch_ready = ~full;

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .din       (bus.fetch_pred),
    .pop       (resolve & ~mispred),
    .clear     (mispred),
    .full      (full),
    .empty     (empty),
    .head_data (head_pred)
  );

  // Registered update strobe, flush pulse and redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.flush       <= 1'b0;
      bus.redirect_pc <= ADDR_W'(RESET_PC);
      bus.upd_valid   <= 1'b0;
      bus.upd_taken   <= 1'b0;
      bus.underflow   <= 1'b0;
    end else begin
      bus.upd_valid <= resolve;
      bus.flush     <= mispred;
      if (resolve) begin
        bus.upd_taken <= bus.exe_taken;
      end
      if (mispred) begin
        bus.redirect_pc <= bus.exe_taken ? bus.exe_target
                                         : bus.exe_pc_plus4;
      end
      if (bus.exe_valid & empty) begin
        bus.underflow <= 1'b1;
      end
    end
  end

`ifdef BR_PERF_CNT_EN
  // Saturating resolve and mispredict counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.perf_branches    <= '0;
      bus.perf_mispredicts <= '0;
    end else begin
      if (resolve && bus.perf_branches != '1) begin
        bus.perf_branches <= bus.perf_branches + 1'b1;
      end
      if (mispred && bus.perf_mispredicts != '1) begin
        bus.perf_mispredicts <= bus.perf_mispredicts + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized bench for branch_resolver with a queue-based model.
// Define BR_PERF_CNT_EN to also check the perf counters.
module tb_branch_resolver;
  import br_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_resolver_if #(.ADDR_W(ADDR_W)) ifc ();

  branch_resolver #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int pass_cnt = 0;
  int total    = 0;

  bit          q[$];
  bit          m_flush;
  bit          m_upd_v;
  bit          m_upd_t;
  bit          m_uf;
  logic [31:0] m_redir;
  longint      m_br;
  longint      m_mis;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Per-cycle comparison against the model.
  task automatic compare();
    chk("fetch_ready", 32'(ifc.fetch_ready), 32'(q.size() < DEPTH));
    chk("flush", 32'(ifc.flush), 32'(m_flush));
    chk("upd_valid", 32'(ifc.upd_valid), 32'(m_upd_v));
    chk("underflow", 32'(ifc.underflow), 32'(m_uf));
    if (m_flush) chk("redirect_pc", ifc.redirect_pc, m_redir);
    if (m_upd_v) chk("upd_taken", 32'(ifc.upd_taken), 32'(m_upd_t));
`ifdef BR_PERF_CNT_EN
    chk("perf_branches", ifc.perf_branches,
        (m_br > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_br));
    chk("perf_mispredicts", ifc.perf_mispredicts,
        (m_mis > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_mis));
`endif
  endtask

  // Apply one cycle of inputs, advance model, then compare.
  task automatic step(bit r, bit fv, bit fp, bit ev, bit et,
                      logic [31:0] tgt, logic [31:0] pc4);
    bit was_full;
    rst              = r;
    ifc.fetch_valid  = fv;
    ifc.fetch_pred   = fp;
    ifc.exe_valid    = ev;
    ifc.exe_taken    = et;
    ifc.exe_target   = tgt;
    ifc.exe_pc_plus4 = pc4;
    was_full = q.size() == DEPTH;
    if (r) begin
      q.delete();
      m_flush = 0; m_upd_v = 0; m_upd_t = 0;
      m_uf = 0; m_redir = 0; m_br = 0; m_mis = 0;
    end else begin
      m_flush = 0;
      m_upd_v = 0;
      if (ev && q.size() == 0) begin
        m_uf = 1;
        if (fv) q.push_back(fp);
      end else if (ev) begin
        m_upd_v = 1;
        m_upd_t = et;
        m_br++;
        if (q[0] != et) begin
          m_flush = 1;
          m_mis++;
          m_redir = et ? tgt : pc4;
          q.delete();
        end else begin
          void'(q.pop_front());
          if (fv && !was_full) q.push_back(fp);
        end
      end else if (fv && !was_full) begin
        q.push_back(fp);
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    ifc.fetch_valid = 0; ifc.fetch_pred = 0;
    ifc.exe_valid = 0; ifc.exe_taken = 0;
    ifc.exe_target = 0; ifc.exe_pc_plus4 = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", 32'(ifc.fetch_ready), 1);
    chk("rst_redirect", ifc.redirect_pc, 0);
    chk("rst_upd_taken", 32'(ifc.upd_taken), 0);

    // 1: correct taken prediction
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h200, 32'h4);
    chk("t1_upd_valid", 32'(ifc.upd_valid), 1);
    chk("t1_upd_taken", 32'(ifc.upd_taken), 1);
    chk("t1_flush", 32'(ifc.flush), 0);
    idle();
    chk("t1_upd_pulse", 32'(ifc.upd_valid), 0);

    // 2: predicted not-taken, actually taken
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h100, 32'h8);
    chk("t2_flush", 32'(ifc.flush), 1);
    chk("t2_redirect", ifc.redirect_pc, 32'h100);
    chk("t2_ready", 32'(ifc.fetch_ready), 1);
    idle();

    // 3: mispredict with same-cycle push dropped
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 32'h300, 32'h44);
    chk("t3_flush", 32'(ifc.flush), 1);
    chk("t3_redirect", ifc.redirect_pc, 32'h44);
    chk("t3_ready", 32'(ifc.fetch_ready), 1);
    chk("t3_model_empty", 32'(q.size()), 0);
    idle();

    // 4: fill, overflow push, drain
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 0, 0, 0, 0);
    chk("t4_full", 32'(ifc.fetch_ready), 0);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 1, 1, 32'h40, 32'h50);
      chk("t4_upd", 32'(ifc.upd_valid), 1);
      chk("t4_noflush", 32'(ifc.flush), 0);
    end
    chk("t4_drained", 32'(ifc.fetch_ready), 1);

    // 5: underflow is sticky until reset
    step(0, 0, 0, 1, 1, 0, 0);
    chk("t5_uf", 32'(ifc.underflow), 1);
    chk("t5_noupd", 32'(ifc.upd_valid), 0);
    idle();
    chk("t5_uf_hold", 32'(ifc.underflow), 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t5_uf_clr", 32'(ifc.underflow), 0);

`ifdef BR_PERF_CNT_EN
    // 6: three resolves, one mispredict
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 32'h80, 0);
    chk("t6_br", ifc.perf_branches, 3);
    chk("t6_mis", ifc.perf_mispredicts, 1);
    step(1, 0, 0, 0, 0, 0, 0);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 4, 1'($urandom),
           $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
